projectile_ctl: RTL and testbench

Parametrised 2-D ballistic trajectory generator driving a sprite position on the game screen. On a start request it latches launch position, velocity and ground level, then advances x/y once per physics tick with per-tick gravity, terminating on ground contact, side-wall contact or abort. It sits between game-logic control (throw trigger, aim/power) and the sprite draw pipeline. It replaces the fixed-parameter, vertical-only throw controller with horizontal motion, configurable timing and physics, and a start/done handshake.

---
 rtl/projectile_ctl.sv | 233 +++++++++++++++++++++++
 tb/tb_projectile_ctl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/projectile_ctl.sv
// projectile_ctl
//   2-D ballistic trajectory generator for a sprite. A start request in IDLE
//   latches launch position, velocity and ground row. While in FLIGHT, x/y
//   advance once per physics tick (every CLK_PER_TICK clocks) with gravity
//   applied to vy. Flight ends on ground contact, side-wall contact or abort.
//
// Ports
//   clk       in   clock
//   rst       in   synchronous, active-high reset
//   start     in   launch request (sampled only in IDLE)
//   abort     in   terminate flight (sampled only in FLIGHT)
//   x0, y0    in   signed launch position
//   vx0, vy0  in   signed launch velocity (vy0 > 0 moves up the screen)
//   ground_y  in   signed landing row
//   x_pos     out  registered sprite x
//   y_pos     out  registered sprite y
//   busy      out  high while in FLIGHT
//   done      out  one-cycle pulse at flight end
//   status    out  end cause: 0 none, 1 landed, 2 wall, 3 aborted
module projectile_ctl #(
  parameter int CLK_PER_TICK = 1300000,
  parameter int POS_W        = 12,
  parameter int VEL_W        = 8,
  parameter int GRAVITY      = 1,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 1023,
  parameter int X_RESET      = 500,
  parameter int Y_RESET      = 350
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic signed [POS_W-1:0] x0,
  input  logic signed [POS_W-1:0] y0,
  input  logic signed [VEL_W-1:0] vx0,
  input  logic signed [VEL_W-1:0] vy0,
  input  logic signed [POS_W-1:0] ground_y,
  output logic signed [POS_W-1:0] x_pos,
  output logic signed [POS_W-1:0] y_pos,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              status
);

  localparam int CNT_W = (CLK_PER_TICK > 2) ? $clog2(CLK_PER_TICK) : 1;
  // Two guard bits let x+vx / y-vy be compared without overflow.
  localparam int EXT_W = POS_W + 2;

  localparam logic [CNT_W-1:0]        TICK_LAST = CNT_W'(CLK_PER_TICK - 1);
  localparam logic signed [EXT_W-1:0] X_MIN_E   = EXT_W'(X_MIN);
  localparam logic signed [EXT_W-1:0] X_MAX_E   = EXT_W'(X_MAX);
  localparam logic signed [VEL_W:0]   GRAV_E    = (VEL_W + 1)'(GRAVITY);
  localparam logic signed [VEL_W:0]   VY_MIN_E  = (VEL_W + 1)'(-(2 ** (VEL_W - 1)));

  localparam logic [1:0] ST_NONE   = 2'd0;
  localparam logic [1:0] ST_LANDED = 2'd1;
  localparam logic [1:0] ST_WALL   = 2'd2;
  localparam logic [1:0] ST_ABORT  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FLIGHT = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                  r_state;
  logic signed [POS_W-1:0] r_x;
  logic signed [POS_W-1:0] r_y;
  logic signed [VEL_W-1:0] r_vx;
  logic signed [VEL_W-1:0] r_vy;
  logic signed [POS_W-1:0] r_gnd;
  logic [CNT_W-1:0]        r_tick_cnt;
  logic [1:0]              r_status;
  logic                    r_busy;
  logic                    r_done;

  state_t                  w_state_next;
  logic signed [POS_W-1:0] w_x_next;
  logic signed [POS_W-1:0] w_y_next;
  logic signed [VEL_W-1:0] w_vx_next;
  logic signed [VEL_W-1:0] w_vy_next;
  logic signed [POS_W-1:0] w_gnd_next;
  logic [CNT_W-1:0]        w_tick_cnt_next;
  logic [1:0]              w_status_next;
  logic                    w_busy_next;
  logic                    w_done_next;

  // Sign-extended operands and per-tick arithmetic.
  logic signed [EXT_W-1:0] w_x_ext;
  logic signed [EXT_W-1:0] w_y_ext;
  logic signed [EXT_W-1:0] w_vx_ext;
  logic signed [EXT_W-1:0] w_vy_ext;
  logic signed [EXT_W-1:0] w_gnd_ext;
  logic signed [EXT_W-1:0] w_x_step;
  logic signed [EXT_W-1:0] w_y_step;
  logic signed [POS_W-1:0] w_x_clamp;
  logic                    w_x_out;
  logic signed [VEL_W:0]   w_vy_dec;
  logic signed [VEL_W-1:0] w_vy_sat;
  logic                    w_tick;

  assign w_x_ext   = {{(EXT_W - POS_W){r_x[POS_W-1]}}, r_x};
  assign w_y_ext   = {{(EXT_W - POS_W){r_y[POS_W-1]}}, r_y};
  assign w_gnd_ext = {{(EXT_W - POS_W){r_gnd[POS_W-1]}}, r_gnd};
  assign w_vx_ext  = {{(EXT_W - VEL_W){r_vx[VEL_W-1]}}, r_vx};
  assign w_vy_ext  = {{(EXT_W - VEL_W){r_vy[VEL_W-1]}}, r_vy};

  // Screen y grows downward, so positive (upward) vy reduces y.
  assign w_x_step = w_x_ext + w_vx_ext;
  assign w_y_step = w_y_ext - w_vy_ext;

  assign w_x_out = (w_x_step < X_MIN_E) || (w_x_step > X_MAX_E);

  always_comb begin
    w_x_clamp = w_x_step[POS_W-1:0];
    if (w_x_step < X_MIN_E) begin
      w_x_clamp = X_MIN_E[POS_W-1:0];
    end else if (w_x_step > X_MAX_E) begin
      w_x_clamp = X_MAX_E[POS_W-1:0];
    end
  end

  // One extra bit holds vy - GRAVITY exactly; saturate at the most negative vy.
  assign w_vy_dec = {r_vy[VEL_W-1], r_vy} - GRAV_E;
  assign w_vy_sat = (w_vy_dec < VY_MIN_E) ? VY_MIN_E[VEL_W-1:0] : w_vy_dec[VEL_W-1:0];

  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_comb begin
    w_state_next    = r_state;
    w_x_next        = r_x;
    w_y_next        = r_y;
    w_vx_next       = r_vx;
    w_vy_next       = r_vy;
    w_gnd_next      = r_gnd;
    w_tick_cnt_next = r_tick_cnt;
    w_status_next   = r_status;
    w_busy_next     = 1'b0;
    w_done_next     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next    = S_FLIGHT;
          w_x_next        = x0;
          w_y_next        = y0;
          w_vx_next       = vx0;
          w_vy_next       = vy0;
          w_gnd_next      = ground_y;
          w_tick_cnt_next = '0;
          w_status_next   = ST_NONE;
          w_busy_next     = 1'b1;
        end
      end

      S_FLIGHT: begin
        w_busy_next     = 1'b1;
        w_tick_cnt_next = w_tick ? '0 : r_tick_cnt + 1'b1;
        if (abort) begin
          // Abort wins even on a tick cycle: the pending update is dropped.
          w_state_next  = S_DONE;
          w_status_next = ST_ABORT;
          w_busy_next   = 1'b0;
          w_done_next   = 1'b1;
        end else if (w_tick) begin
          w_vy_next = w_vy_sat;
          if (w_y_step >= w_gnd_ext) begin
            w_x_next      = w_x_clamp;
            w_y_next      = r_gnd;
            w_status_next = ST_LANDED;
            w_state_next  = S_DONE;
            w_busy_next   = 1'b0;
            w_done_next   = 1'b1;
          end else if (w_x_out) begin
            w_x_next      = w_x_clamp;
            w_y_next      = w_y_step[POS_W-1:0];
            w_status_next = ST_WALL;
            w_state_next  = S_DONE;
            w_busy_next   = 1'b0;
            w_done_next   = 1'b1;
          end else begin
            w_x_next = w_x_step[POS_W-1:0];
            w_y_next = w_y_step[POS_W-1:0];
          end
        end
      end

      S_DONE: begin
        // One-cycle landing pad so done is a single pulse and a held start
        // cannot relaunch before IDLE is reached.
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_x        <= POS_W'(X_RESET);
      r_y        <= POS_W'(Y_RESET);
      r_vx       <= '0;
      r_vy       <= '0;
      r_gnd      <= '0;
      r_tick_cnt <= '0;
      r_status   <= ST_NONE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_x        <= w_x_next;
      r_y        <= w_y_next;
      r_vx       <= w_vx_next;
      r_vy       <= w_vy_next;
      r_gnd      <= w_gnd_next;
      r_tick_cnt <= w_tick_cnt_next;
      r_status   <= w_status_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
    end
  end

  assign x_pos  = r_x;
  assign y_pos  = r_y;
  assign busy   = r_busy;
  assign done   = r_done;
  assign status = r_status;

endmodule

// File: tb/tb_projectile_ctl.sv
// tb_projectile_ctl
//   Directed bench for projectile_ctl. Instance dut runs with a 4-clock tick
//   and default physics; instance dut_sat uses a 4-bit velocity and
//   GRAVITY=3 with a 2-clock tick to exercise vy saturation. Inputs change
//   and outputs are sampled on the falling edge.
module tb_projectile_ctl;

  localparam int CPT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic signed [11:0] x0 = '0;
  logic signed [11:0] y0 = '0;
  logic signed [7:0]  vx0 = '0;
  logic signed [7:0]  vy0 = '0;
  logic signed [11:0] ground_y = '0;
  logic signed [11:0] x_pos;
  logic signed [11:0] y_pos;
  logic               busy;
  logic               done;
  logic [1:0]         status;

  logic               s_start = 1'b0;
  logic               s_abort = 1'b0;
  logic signed [11:0] s_x0 = '0;
  logic signed [11:0] s_y0 = '0;
  logic signed [3:0]  s_vx0 = '0;
  logic signed [3:0]  s_vy0 = '0;
  logic signed [11:0] s_ground_y = '0;
  logic signed [11:0] s_x_pos;
  logic signed [11:0] s_y_pos;
  logic               s_busy;
  logic               s_done;
  logic [1:0]         s_status;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  projectile_ctl #(
    .CLK_PER_TICK(CPT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .x0(x0), .y0(y0), .vx0(vx0), .vy0(vy0), .ground_y(ground_y),
    .x_pos(x_pos), .y_pos(y_pos), .busy(busy), .done(done), .status(status)
  );

  projectile_ctl #(
    .CLK_PER_TICK(2),
    .VEL_W(4),
    .GRAVITY(3)
  ) dut_sat (
    .clk(clk), .rst(rst), .start(s_start), .abort(s_abort),
    .x0(s_x0), .y0(s_y0), .vx0(s_vx0), .vy0(s_vy0), .ground_y(s_ground_y),
    .x_pos(s_x_pos), .y_pos(s_y_pos), .busy(s_busy), .done(s_done), .status(s_status)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // y after ticks 1..7 of the arc launch (vy0=3, gravity 1).
  int arc_y [1:7] = '{597, 595, 594, 594, 595, 597, 600};
  // Saturation run: y after ticks 1..6 (vy 0,-3,-6,-8,-8,-8 applied in turn).
  int sat_y [1:6] = '{0, 3, 9, 17, 25, 33};

  initial begin
    // ---------------- reset state ----------------
    step(2);
    check("rst x_pos", x_pos, 500);
    check("rst y_pos", y_pos, 350);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst status", status, 0);
    rst = 1'b0;
    step(1);

    // ---------------- arc, start held high ----------------
    x0 = 12'sd100; y0 = 12'sd600; vx0 = 8'sd2; vy0 = 8'sd3; ground_y = 12'sd600;
    start = 1'b1;
    step(1);
    check("arc launch busy", busy, 1);
    check("arc launch x", x_pos, 100);
    check("arc launch y", y_pos, 600);
    check("arc launch status", status, 0);
    for (int k = 1; k <= 6; k++) begin
      step(CPT);
      check($sformatf("arc t%0d x", k), x_pos, 100 + 2 * k);
      check($sformatf("arc t%0d y", k), y_pos, arc_y[k]);
      check($sformatf("arc t%0d busy", k), busy, 1);
    end
    step(CPT);
    check("arc land done", done, 1);
    check("arc land busy", busy, 0);
    check("arc land status", status, 1);
    check("arc land x", x_pos, 114);
    check("arc land y", y_pos, arc_y[7]);
    step(1);
    check("hs done width", done, 0);
    check("hs no early relaunch", busy, 0);
    check("hs status held", status, 1);
    step(1);
    check("hs relaunch busy", busy, 1);
    check("hs relaunch x", x_pos, 100);
    check("hs relaunch status", status, 0);
    start = 1'b0;

    // ---------------- abort on the 3rd tick's wrap cycle ----------------
    step(CPT);
    check("ab t1 x", x_pos, 102);
    step(CPT);
    check("ab t2 y", y_pos, 595);
    step(CPT - 1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("ab done", done, 1);
    check("ab status", status, 3);
    check("ab busy", busy, 0);
    check("ab x held", x_pos, 104);
    check("ab y held", y_pos, 595);
    step(1);
    check("ab done width", done, 0);
    abort = 1'b1;
    step(2);
    abort = 1'b0;
    check("idle abort ignored status", status, 3);
    check("idle abort ignored done", done, 0);

    // ---------------- wall ----------------
    // 1020+3 = 1023 is still inside the inclusive limit; tick 2 crosses it.
    x0 = 12'sd1020; y0 = 12'sd300; vx0 = 8'sd3; vy0 = 8'sd5; ground_y = 12'sd700;
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("wall launch busy", busy, 1);
    step(CPT);
    check("wall t1 x", x_pos, 1023);
    check("wall t1 y", y_pos, 295);
    check("wall t1 busy", busy, 1);
    step(CPT);
    check("wall t2 x clamped", x_pos, 1023);
    check("wall t2 y", y_pos, 291);
    check("wall t2 status", status, 2);
    check("wall t2 done", done, 1);
    step(1);
    check("wall done width", done, 0);

    // ---------------- reset mid-flight, start held during rst ----------------
    x0 = 12'sd100; y0 = 12'sd600; vx0 = 8'sd2; vy0 = 8'sd3; ground_y = 12'sd600;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(CPT + 2);
    check("mid x before rst", x_pos, 102);
    rst = 1'b1;
    start = 1'b1;
    step(1);
    rst = 1'b0;
    start = 1'b0;
    check("mid rst x", x_pos, 500);
    check("mid rst y", y_pos, 350);
    check("mid rst busy", busy, 0);
    check("mid rst done", done, 0);
    check("mid rst status", status, 0);
    step(2);
    check("post rst idle", busy, 0);

    // ---------------- vy saturation (VEL_W=4, GRAVITY=3) ----------------
    s_x0 = 12'sd100; s_y0 = 12'sd0; s_vx0 = 4'sd0; s_vy0 = 4'sd0; s_ground_y = 12'sd2000;
    s_start = 1'b1;
    step(1);
    s_start = 1'b0;
    check("sat launch y", s_y_pos, 0);
    for (int k = 1; k <= 6; k++) begin
      step(2);
      check($sformatf("sat t%0d y", k), s_y_pos, sat_y[k]);
    end
    check("sat busy", s_busy, 1);
    s_abort = 1'b1;
    step(1);
    s_abort = 1'b0;
    check("sat abort status", s_status, 3);
    check("sat abort done", s_done, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
